// File: rtl/genie_arb_pkg.sv
// -----------------------------------------------------------------------------
// genie_arb_pkg
// Shared definitions for the genie family of arbiters.
//   src_w(n)                 : width of a source index for n requesters,
//                              never less than 1 bit.
//   rr_next(valid, last, n)  : round-robin scan. Returns the first set bit of
//                              valid[n-1:0] starting at last+1 and wrapping
//                              modulo n, plus a found flag.
// The scan works on a fixed-width valid vector so a single function serves
// every arbiter size up to ARB_MAX_NI requesters.
// -----------------------------------------------------------------------------
package genie_arb_pkg;

  localparam int ARB_MAX_NI = 64;
  localparam int ARB_IDX_W  = $clog2(ARB_MAX_NI);

  typedef struct packed {
    logic                 found;
    logic [ARB_IDX_W-1:0] idx;
  } rr_pick_t;

  function automatic int src_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // last is always < n, and off runs 1..n, so last+off < 2n: a single
  // conditional subtract replaces a modulo by a non-power-of-two.
  function automatic rr_pick_t rr_next(input logic [ARB_MAX_NI-1:0] valid,
                                       input int last,
                                       input int n);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int off = 1; off <= ARB_MAX_NI; off++) begin
      if (off <= n && !r.found) begin
        k = last + off;
        if (k >= n) begin
          k = k - n;
        end
        if (valid[ARB_IDX_W'(k)]) begin
          r.found = 1'b1;
          r.idx   = ARB_IDX_W'(k);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/genie_rr_pick.sv
// -----------------------------------------------------------------------------
// genie_rr_pick
// Purely combinational round-robin picker.
// Ports:
//   valid [NI]   : request vector
//   last  [SRCW] : index granted most recently; the scan starts just above it
//   idx   [SRCW] : chosen requester (meaningless when found = 0)
//   found        : at least one requester is valid
// NI must not exceed genie_arb_pkg::ARB_MAX_NI.
// -----------------------------------------------------------------------------
module genie_rr_pick
  import genie_arb_pkg::*;
#(
  parameter int NI   = 2,
  parameter int SRCW = 1
) (
  input  logic [NI-1:0]   valid,
  input  logic [SRCW-1:0] last,
  output logic [SRCW-1:0] idx,
  output logic            found
);

  logic [ARB_MAX_NI-1:0] valid_ext;
  rr_pick_t              pick;

  always_comb begin
    valid_ext         = '0;
    valid_ext[NI-1:0] = valid;
    pick              = rr_next(valid_ext, int'(last), NI);
    idx               = SRCW'(pick.idx);
    found             = pick.found;
  end

endmodule

// File: rtl/genie_delay_arb.sv
// -----------------------------------------------------------------------------
// genie_delay_arb
// Packet-aware round-robin arbiter in front of one genie_mem_delay channel.
// A requester keeps the grant from its first accepted beat until its eop beat
// is accepted; the winning beat is registered together with its source index.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   i_data  [NI*WIDTH]    : requester k data in slice [k*WIDTH +: WIDTH]
//   i_eop   [NI]          : last beat of packet, per requester
//   i_valid [NI]          : beat valid, per requester
//   i_ready [NI]          : beat accepted when i_valid[k] && i_ready[k]
//   o_data  [WIDTH]       : registered winning beat
//   o_eop                 : registered eop
//   o_src   [SRCW]        : requester that produced the beat
//   o_valid               : output beat valid
//   i_ready_out           : downstream accepts the output beat
// -----------------------------------------------------------------------------
module genie_delay_arb
  import genie_arb_pkg::*;
#(
  parameter int NI    = 2,
  parameter int WIDTH = 32,
  parameter int SRCW  = src_w(NI)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NI*WIDTH-1:0]   i_data,
  input  logic [NI-1:0]         i_eop,
  input  logic [NI-1:0]         i_valid,
  output logic [NI-1:0]         i_ready,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_eop,
  output logic [SRCW-1:0]       o_src,
  output logic                  o_valid,
  input  logic                  i_ready_out
);

  // Arbitration state
  logic [SRCW-1:0]  last_q,     last_d;
  logic             locked_q,   locked_d;
  logic [SRCW-1:0]  lock_idx_q, lock_idx_d;

  // Output register
  logic [WIDTH-1:0] o_data_q,   o_data_d;
  logic             o_eop_q,    o_eop_d;
  logic [SRCW-1:0]  o_src_q,    o_src_d;
  logic             o_valid_q,  o_valid_d;

  logic [WIDTH-1:0] req_data [NI];
  logic [SRCW-1:0]  pick_idx;
  logic             pick_found;
  logic [SRCW-1:0]  cand_idx;
  logic             cand_found;
  logic             load;
  logic             grant_ok;
  logic             xfer;

  genie_rr_pick #(
    .NI   (NI),
    .SRCW (SRCW)
  ) u_pick (
    .valid (i_valid),
    .last  (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Output register can accept a new beat when empty or being drained.
  assign load = !o_valid_q || i_ready_out;

  // While locked the candidate is fixed regardless of i_valid, so the locked
  // requester's ready never depends on its own valid and nobody else can
  // sneak in during a mid-packet bubble.
  assign cand_idx   = locked_q ? lock_idx_q : pick_idx;
  assign cand_found = locked_q || pick_found;
  assign grant_ok   = reset && load && cand_found;
  assign xfer       = grant_ok && i_valid[cand_idx];

  for (genvar gi = 0; gi < NI; gi++) begin : g_req
    assign req_data[gi] = i_data[gi*WIDTH +: WIDTH];
    assign i_ready[gi]  = grant_ok && (cand_idx == SRCW'(gi));
  end

  always_comb begin
    last_d     = last_q;
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    o_data_d   = o_data_q;
    o_eop_d    = o_eop_q;
    o_src_d    = o_src_q;
    o_valid_d  = o_valid_q;

    if (xfer) begin
      o_data_d  = req_data[cand_idx];
      o_eop_d   = i_eop[cand_idx];
      o_src_d   = cand_idx;
      o_valid_d = 1'b1;
      last_d    = cand_idx;
      if (i_eop[cand_idx]) begin
        locked_d = 1'b0;
      end else begin
        locked_d   = 1'b1;
        lock_idx_d = cand_idx;
      end
    end else if (o_valid_q && i_ready_out) begin
      // Drained with nothing to replace it; payload fields simply hold.
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // last = NI-1 makes requester 0 the first winner out of reset.
      last_q     <= SRCW'(NI - 1);
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
      o_data_q   <= '0;
      o_eop_q    <= 1'b0;
      o_src_q    <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      last_q     <= last_d;
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
      o_data_q   <= o_data_d;
      o_eop_q    <= o_eop_d;
      o_src_q    <= o_src_d;
      o_valid_q  <= o_valid_d;
    end
  end

  assign o_data  = o_data_q;
  assign o_eop   = o_eop_q;
  assign o_src   = o_src_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_genie_delay_arb.sv
// -----------------------------------------------------------------------------
// tb_genie_delay_arb
// Directed scoreboard bench for genie_delay_arb with three requesters.
// Each requester is modelled as a list of packet lengths; beat data encodes
// {requester, packet number, beat number}. Tests push the hand-ordered
// expected output beats into a queue; a monitor pops and compares on every
// output handshake.
// -----------------------------------------------------------------------------
module tb_genie_delay_arb;

  localparam int NI    = 3;
  localparam int WIDTH = 32;
  localparam int SRCW  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NI*WIDTH-1:0] i_data;
  logic [NI-1:0]       i_eop;
  logic [NI-1:0]       i_valid;
  logic [NI-1:0]       i_ready;
  logic [WIDTH-1:0]    o_data;
  logic                o_eop;
  logic [SRCW-1:0]     o_src;
  logic                o_valid;
  logic                i_ready_out;

  always #5 clk = ~clk;

  genie_delay_arb #(
    .NI    (NI),
    .WIDTH (WIDTH),
    .SRCW  (SRCW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_data      (i_data),
    .i_eop       (i_eop),
    .i_valid     (i_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_eop       (o_eop),
    .o_src       (o_src),
    .o_valid     (o_valid),
    .i_ready_out (i_ready_out)
  );

  typedef struct packed {
    logic [SRCW-1:0]  src;
    logic [WIDTH-1:0] data;
    logic             eop;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  int          len_q[NI][$];
  int          beat_n[NI];
  int          pkt_n[NI];
  logic [NI-1:0] valid_en;
  logic        rdy_en;

  function automatic logic [WIDTH-1:0] mk_data(input int k, input int p, input int b);
    return {8'(k), 8'(p), 16'(b)};
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_beat(input int k, input int p, input int b, input logic eop);
    beat_t e;
    e.src  = SRCW'(k);
    e.data = mk_data(k, p, b);
    e.eop  = eop;
    exp_q.push_back(e);
  endtask

  // Present each requester's current beat (if enabled and it has a packet).
  task automatic drive();
    for (int k = 0; k < NI; k++) begin
      if (valid_en[k] && len_q[k].size() > 0) begin
        i_valid[k]                 = 1'b1;
        i_eop[k]                   = (beat_n[k] + 1 == len_q[k][0]);
        i_data[k*WIDTH +: WIDTH]   = mk_data(k, pkt_n[k], beat_n[k]);
      end else begin
        i_valid[k]                 = 1'b0;
        i_eop[k]                   = 1'b0;
        i_data[k*WIDTH +: WIDTH]   = '0;
      end
    end
    i_ready_out = rdy_en;
    #1;
  endtask

  // One clock: record input handshakes mid-cycle, then advance the
  // requester models after the edge.
  task automatic tick();
    logic [NI-1:0] acc;
    @(negedge clk);
    acc = i_valid & i_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      if (acc[k] && len_q[k].size() > 0) begin
        beat_n[k]++;
        if (beat_n[k] == len_q[k][0]) begin
          void'(len_q[k].pop_front());
          beat_n[k] = 0;
          pkt_n[k]++;
        end
      end
    end
  endtask

  task automatic step();
    drive();
    tick();
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NI; k++) s += len_q[k].size();
    return s;
  endfunction

  task automatic run_until_done();
    int budget = 60;
    while (budget > 0 && pending() > 0) begin
      step();
      budget--;
    end
    chk("pkts_pending", pending(), 0);
  endtask

  task automatic drain();
    int budget = 10;
    while (budget > 0 && exp_q.size() > 0) begin
      step();
      budget--;
    end
    chk("exp_left", exp_q.size(), 0);
  endtask

  // Scoreboard monitor: one line per delivered beat.
  always @(negedge clk) begin
    beat_t e;
    if (reset && o_valid && i_ready_out) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL extra_beat: got src=%0d data=%08h eop=%0d expected none", o_src, o_data, o_eop);
      end else begin
        e = exp_q.pop_front();
        $display("beat src=%0d data=%08h eop=%0d (exp src=%0d data=%08h eop=%0d)",
                 o_src, o_data, o_eop, e.src, e.data, e.eop);
        chk("out_src",  WIDTH'(o_src), WIDTH'(e.src));
        chk("out_data", o_data, e.data);
        chk("out_eop",  WIDTH'(o_eop), WIDTH'(e.eop));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset       = 1'b0;
    valid_en    = '0;
    rdy_en      = 1'b1;
    i_ready_out = 1'b1;
    i_valid     = '1;
    i_eop       = '1;
    i_data      = '1;
    for (int k = 0; k < NI; k++) begin
      beat_n[k] = 0;
      pkt_n[k]  = 0;
    end

    // Reset state, with every requester asking.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_o_valid", WIDTH'(o_valid), 0);
    chk("rst_o_data",  o_data, 0);
    chk("rst_o_eop",   WIDTH'(o_eop), 0);
    chk("rst_o_src",   WIDTH'(o_src), 0);
    chk("rst_i_ready", WIDTH'(i_ready), 0);
    reset = 1'b1;

    // Round robin with single-beat packets: 0,1,2,0,1,2 back to back.
    for (int k = 0; k < NI; k++) begin
      len_q[k].push_back(1);
      len_q[k].push_back(1);
    end
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < NI; k++) expect_beat(k, p, 0, 1'b1);
    valid_en = '1;
    step();
    for (int c = 0; c < 6; c++) begin
      drive();
      chk("rr_o_valid", WIDTH'(o_valid), 1);
      tick();
    end
    drain();

    // Packet lock: req0 4-beat packet, req1 waiting the whole time.
    len_q[0].push_back(4);
    len_q[1].push_back(1);
    for (int b = 0; b < 4; b++) expect_beat(0, 2, b, b == 3);
    expect_beat(1, 2, 0, 1'b1);
    valid_en = 3'b011;
    for (int c = 0; c < 4; c++) begin
      drive();
      chk("lock_i_ready", WIDTH'(i_ready), 3'b001);
      tick();
    end
    drive();
    chk("switch_i_ready", WIDTH'(i_ready), 3'b010);
    tick();
    drain();

    // Locked bubble: req0 drops valid for 2 cycles mid-packet.
    len_q[0].push_back(6);
    len_q[1].push_back(1);
    for (int b = 0; b < 6; b++) expect_beat(0, 3, b, b == 5);
    expect_beat(1, 3, 0, 1'b1);
    valid_en = 3'b011;
    repeat (2) step();
    valid_en = 3'b010;
    for (int c = 0; c < 2; c++) begin
      drive();
      chk("bubble_i_ready", WIDTH'(i_ready), 3'b001);
      tick();
      chk("bubble_o_valid", WIDTH'(o_valid), 0);
    end
    valid_en = 3'b011;
    drive();
    chk("resume_i_ready", WIDTH'(i_ready), 3'b001);
    tick();
    run_until_done();
    drain();

    // Backpressure: 3 stalled cycles holding req2's first beat.
    len_q[2].push_back(3);
    for (int b = 0; b < 3; b++) expect_beat(2, 2, b, b == 2);
    valid_en = 3'b100;
    step();
    rdy_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive();
      chk("stall_i_ready", WIDTH'(i_ready), 0);
      chk("stall_o_valid", WIDTH'(o_valid), 1);
      chk("stall_o_data",  o_data, mk_data(2, 2, 0));
      chk("stall_o_src",   WIDTH'(o_src), 2);
      tick();
    end
    rdy_en = 1'b1;
    run_until_done();
    drain();

    // Reset during beat 2 of req1's packet: the in-flight beat is dropped.
    len_q[1].push_back(3);
    expect_beat(1, 4, 0, 1'b0);
    valid_en = 3'b010;
    step();
    step();
    reset = 1'b0;
    drive();
    chk("rstmid_i_ready", WIDTH'(i_ready), 0);
    tick();
    chk("rstmid_o_valid", WIDTH'(o_valid), 0);
    void'(len_q[1].pop_front());
    beat_n[1] = 0;
    pkt_n[1]++;
    reset = 1'b1;
    len_q[0].push_back(2);
    len_q[1].push_back(1);
    expect_beat(0, 4, 0, 1'b0);
    expect_beat(0, 4, 1, 1'b1);
    expect_beat(1, 5, 0, 1'b1);
    valid_en = 3'b011;
    drive();
    chk("postrst_i_ready", WIDTH'(i_ready), 3'b001);
    tick();
    run_until_done();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/genie_delay_arb.md
# genie_delay_arb

Packet-aware round-robin arbiter that shares one `genie_mem_delay` channel between NI ready/valid requesters. It selects one requester, holds the grant until that requester's end-of-packet beat is accepted, and registers the winning beat with its source index so the delayed stream can be demultiplexed downstream. It sits directly upstream of the delay line, and its output port connects to the delay line's input handshake.

## Interface
Parameters:
- NI, 2: number of requesters (1 allowed, giving a registered passthrough)
- WIDTH, 32: data width per beat
- SRCW, derived = max(1, $clog2(NI)): width of source index

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- i_data  in  NI×WIDTH  packed requester data; requester k uses slice [k*WIDTH +: WIDTH]
- i_eop  in  NI  last beat of packet, per requester
- i_valid  in  NI  beat valid, per requester
- i_ready  out  NI  beat accepted when i_valid[k] && i_ready[k]
- o_data  out  WIDTH  registered winning beat
- o_eop  out  1  registered eop
- o_src  out  SRCW  index of requester that produced the beat
- o_valid  out  1  output beat valid
- i_ready_out  in  1  downstream (delay line o_ready) accepts the beat

## Operation
- State:
  - `last`: SRCW, the last granted index.
  - `locked`: 1 bit.
  - `lock_idx`: SRCW.
  - Output register: o_data, o_eop, o_src, o_valid.
- `load` = !o_valid || i_ready_out. The output register can take a beat this cycle.
- Grant selection (combinational):
  - If `locked`, the candidate is `lock_idx`.
  - Otherwise, the candidate is the first k with i_valid[k] = 1, scanning from last+1 upward modulo NI.
  - If no requester is valid, there is no candidate.
- i_ready[k] = reset && load && (k == candidate). At most one bit is set. i_ready must not depend on i_valid[k] when locked.
- Transfer on requester k (k == candidate, i_valid[k], load):
  - o_data, o_eop and o_src are loaded from k, and o_valid is set to 1.
  - `last` is set to k.
  - If !i_eop[k], set `locked` = 1 and `lock_idx` = k.
  - If i_eop[k], set `locked` = 0.
- Output drain: if i_ready_out && o_valid and there is no transfer, o_valid is cleared to 0. The other output fields hold.
- Locked requester idle (i_valid[lock_idx] = 0): bubble. The lock holds, and no other requester is granted.
- Single-beat packet (eop on the first beat): the lock is never set, and the next cycle arbitrates.
- NI = 1: the candidate is always 0. This is a pipeline register with lock tracking only.

## Timing
- Reset values: o_valid = 0, o_data = 0, o_eop = 0, o_src = 0, i_ready = 0. `last` = NI-1, so requester 0 wins first. `locked` = 0.
- Latency: 1 cycle from the accepted input beat to o_valid.
- Throughput: 1 beat/cycle while i_ready_out is held high. A fresh arbitration after an eop costs no bubble.
- Stall: while o_valid && !i_ready_out, all i_ready are 0 and the output register holds stable.
- Reset asserted mid-packet: the lock is dropped and the in-flight output beat is discarded. The upstream packet fragment is the requester's responsibility.
- Switching between requesters occurs only on an accepted eop beat. Beats of two packets never interleave on o_*.

## Structure
- Shared package `genie_arb_pkg` holds:
  - the `src_w(n)` function returning max(1, $clog2(n));
  - the round-robin scan function `rr_next(valid, last)`, for reuse by other genie arbiters.
- Sub-module `genie_rr_pick` (NI, SRCW) is the combinational valid-vector + last → index/found picker. The arbiter top holds the lock state and the output register.

## Test plan
- NI = 3, all valid, all eop = 1, i_ready_out = 1. Expected o_src sequence: 0, 1, 2, 0, 1, 2, with o_valid high every cycle after the first.
- NI = 2:
  - Stimulus: req0 sends a 4-beat packet (eop on beat 4), and req1 is valid throughout.
  - Expected: o_src = 0,0,0,0,1. i_ready[1] stays 0 until req0's eop is accepted.
- Locked bubble:
  - Stimulus: req0 drops valid for 2 cycles mid-packet while req1 is valid.
  - Expected: o_valid = 0 for 2 cycles, no req1 beat appears, and req0 resumes.
- Backpressure:
  - Stimulus: i_ready_out = 0 for 3 cycles with o_valid = 1.
  - Expected: o_data/o_src stable, all i_ready = 0, and no beat lost or duplicated when i_ready_out returns to 1.
- Reset mid-packet:
  - Stimulus: assert reset during beat 2 of req1's packet.
  - Expected: the next cycle shows o_valid = 0 and i_ready = 0. After release, req0 wins first with no lock.
- Random stimulus:
  - NI = 4, random valid/eop/ready over 10k cycles.
  - The scoreboard checks per-source in-order delivery, no packet interleaving, and fairness: no requester waits more than 3 packets.
